// File: rtl/color_sort_ctrl_pkg.sv
// Shared definitions for the colour-sorter controller slice.
//   - class codes (CLS_BLACK .. CLS_UNK)
//   - per-channel level encoding (LVL_L / LVL_M / LVL_H)
//   - FSM state encoding (IDLE / SAMPLE / CLASSIFY / DRIVE / HOLD)
//   - class rule table and 7-segment glyph table (seg[6]=a ... seg[0]=g)
package color_sort_ctrl_pkg;

    localparam logic [3:0] CLS_BLACK  = 4'h0;
    localparam logic [3:0] CLS_RED    = 4'h1;
    localparam logic [3:0] CLS_GREEN  = 4'h2;
    localparam logic [3:0] CLS_BLUE   = 4'h3;
    localparam logic [3:0] CLS_PURPLE = 4'h4;
    localparam logic [3:0] CLS_YELLOW = 4'h5;
    localparam logic [3:0] CLS_WHITE  = 4'h6;
    localparam logic [3:0] CLS_ORANGE = 4'h8;
    localparam logic [3:0] CLS_UNK    = 4'hF;

    typedef enum logic [1:0] {LVL_L, LVL_M, LVL_H} level_t;

    typedef enum logic [2:0] {IDLE, SAMPLE, CLASSIFY, DRIVE, HOLD} state_t;

    // Levels listed as R,G,B; first match wins.
    function automatic logic [3:0] classify(level_t r, level_t g, level_t b);
        if      (r == LVL_H && g == LVL_H && b == LVL_H) return CLS_WHITE;
        else if (r == LVL_L && g == LVL_L && b == LVL_L) return CLS_BLACK;
        else if (r == LVL_H && g == LVL_L && b == LVL_L) return CLS_RED;
        else if (r == LVL_L && g == LVL_H && b == LVL_L) return CLS_GREEN;
        else if (r == LVL_L && g == LVL_L && b == LVL_H) return CLS_BLUE;
        else if (r == LVL_M && g == LVL_L && b == LVL_H) return CLS_PURPLE;
        else if (r == LVL_H && g == LVL_H && b == LVL_L) return CLS_YELLOW;
        else if (r == LVL_H && g == LVL_M && b == LVL_L) return CLS_ORANGE;
        else                                             return CLS_UNK;
    endfunction

    // Hex glyphs; code F (unknown) shows a dash (segment g only).
    function automatic logic [6:0] seg_glyph(logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b0000001;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/color_sort_ctrl_if.sv
// Bus bundle for color_sort_ctrl.
//   master: drives red/green/blue/p/stat_sel, observes the controller outputs
//   slave : the controller side
interface color_sort_ctrl_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
);
    logic [W-1:0]     red;
    logic [W-1:0]     green;
    logic [W-1:0]     blue;
    logic             p;
    logic             motor_l;
    logic             motor_r;
    logic [6:0]       seg;
    logic             pn;
    logic             busy;
    logic [3:0]       cls;
    logic             cls_valid;
    logic [3:0]       stat_sel;
    logic [CNT_W-1:0] stat_cnt;

    modport master (
        output red, green, blue, p, stat_sel,
        input  motor_l, motor_r, seg, pn, busy, cls, cls_valid, stat_cnt
    );

    modport slave (
        input  red, green, blue, p, stat_sel,
        output motor_l, motor_r, seg, pn, busy, cls, cls_valid, stat_cnt
    );
endinterface

// File: rtl/color_sort_ctrl_seg7_hex_dec.sv
// seg7_hex_dec: combinational 4-bit class code -> 7 active-high segments.
//   code : in  4  class code
//   seg  : out 7  seg[6]=a ... seg[0]=g; code F shows '-'
module seg7_hex_dec
    import color_sort_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    assign seg = seg_glyph(code);
endmodule

// File: rtl/color_sort_ctrl.sv
// color_sort_ctrl: per rising edge of p, average NSAMP RGB samples, classify
// into one of nine classes, pulse motor_l or motor_r for MOTOR_CYC clocks and
// show the class on a 7-segment digit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : color_sort_ctrl_if.slave
//              in : red/green/blue [W], p, stat_sel[4]
//              out: motor_l, motor_r, seg[7], pn, busy, cls[4], cls_valid,
//                   stat_cnt[CNT_W]
// Optional feature: define COLOR_SORT_STATS_EN for per-class saturating
// counters readable through stat_sel/stat_cnt; otherwise stat_cnt is 0.
module color_sort_ctrl
    import color_sort_ctrl_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter logic [W-1:0] HI_TH    = 'h97,
    parameter logic [W-1:0] MID_TH   = 'h30,
    parameter int unsigned NSAMP     = 4,
    parameter int unsigned MOTOR_CYC = 8,
    parameter logic [15:0] LEFT_MASK = 16'h0032,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    color_sort_ctrl_if.slave bus
);
    localparam int unsigned LG = $clog2(NSAMP);
    localparam int unsigned AW = W + LG;
    localparam int unsigned SW = LG + 1;
    localparam int unsigned MW = (MOTOR_CYC > 1) ? $clog2(MOTOR_CYC) : 1;

    state_t         state;
    logic           p_q;
    logic [AW-1:0]  acc_r, acc_g, acc_b;
    logic [SW-1:0]  scnt;
    logic [MW-1:0]  mcnt;
    logic           motor_l_q, motor_r_q, busy_q, cls_valid_q;
    logic [3:0]     cls_q;
    logic [6:0]     seg_q;
    logic [W-1:0]   avg_r, avg_g, avg_b;
    logic [3:0]     code;
    logic [6:0]     seg_nxt;
    logic           start;

    function automatic level_t level_of(logic [W-1:0] v);
        if (v >= HI_TH)       return LVL_H;
        else if (v >= MID_TH) return LVL_M;
        else                  return LVL_L;
    endfunction

    assign start = bus.p & ~p_q;

    assign avg_r = acc_r[AW-1:LG];
    assign avg_g = acc_g[AW-1:LG];
    assign avg_b = acc_b[AW-1:LG];
    assign code  = classify(level_of(avg_r), level_of(avg_g), level_of(avg_b));

    seg7_hex_dec u_seg (
        .code (code),
        .seg  (seg_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            p_q         <= 1'b0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            scnt        <= '0;
            mcnt        <= '0;
            motor_l_q   <= 1'b0;
            motor_r_q   <= 1'b0;
            busy_q      <= 1'b0;
            cls_valid_q <= 1'b0;
            cls_q       <= '0;
            seg_q       <= '0;
        end else begin
            p_q         <= bus.p;
            cls_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The start edge itself delivers the first sample.
                    if (start) begin
                        acc_r  <= AW'(bus.red);
                        acc_g  <= AW'(bus.green);
                        acc_b  <= AW'(bus.blue);
                        scnt   <= SW'(1);
                        busy_q <= 1'b1;
                        state  <= (NSAMP == 1) ? CLASSIFY : SAMPLE;
                    end
                end
                SAMPLE: begin
                    acc_r <= acc_r + AW'(bus.red);
                    acc_g <= acc_g + AW'(bus.green);
                    acc_b <= acc_b + AW'(bus.blue);
                    scnt  <= scnt + SW'(1);
                    if (scnt == SW'(NSAMP - 1))
                        state <= CLASSIFY;
                end
                CLASSIFY: begin
                    cls_q       <= code;
                    seg_q       <= seg_nxt;
                    cls_valid_q <= 1'b1;
                    mcnt        <= '0;
                    if (code != CLS_UNK) begin
                        if (LEFT_MASK[code]) motor_l_q <= 1'b1;
                        else                 motor_r_q <= 1'b1;
                        state <= DRIVE;
                    end else begin
                        state <= HOLD;
                    end
                end
                DRIVE: begin
                    mcnt <= mcnt + MW'(1);
                    if (mcnt == MW'(MOTOR_CYC - 1)) begin
                        motor_l_q <= 1'b0;
                        motor_r_q <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.p) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.motor_l   = motor_l_q;
    assign bus.motor_r   = motor_r_q;
    assign bus.seg       = seg_q;
    assign bus.busy      = busy_q;
    assign bus.pn        = busy_q;
    assign bus.cls       = cls_q;
    assign bus.cls_valid = cls_valid_q;

`ifdef COLOR_SORT_STATS_EN
    // Only the nine class codes ever reach cls_q, so other slots stay 0.
    logic [CNT_W-1:0] cnt [16];
    logic [CNT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) cnt[i] <= '0;
            stat_q <= '0;
        end else begin
            stat_q <= cnt[bus.stat_sel];
            if (cls_valid_q && cnt[cls_q] != '1)
                cnt[cls_q] <= cnt[cls_q] + CNT_W'(1);
        end
    end

    assign bus.stat_cnt = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^bus.stat_sel;
    assign bus.stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_color_sort_ctrl.sv
module tb_color_sort_ctrl;
    localparam int W     = 8;
    localparam int NSAMP = 4;
    localparam int MC    = 8;
    localparam int CNT_W = 8;
    localparam logic [15:0] LMASK = 16'h0032;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    color_sort_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();

    color_sort_ctrl #(
        .W(W), .HI_TH(8'h97), .MID_TH(8'h30), .NSAMP(NSAMP),
        .MOTOR_CYC(MC), .LEFT_MASK(LMASK), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference glyph table: abcdefg, F -> dash.
    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h01};

    function automatic string lvl(int v);
        if (v >= 'h97) return "H";
        if (v >= 'h30) return "M";
        return "L";
    endfunction

    function automatic int class_of(int r, int g, int b);
        string s;
        s = {lvl(r), lvl(g), lvl(b)};
        case (s)
            "HHH": return 6;
            "LLL": return 0;
            "HLL": return 1;
            "LHL": return 2;
            "LLH": return 3;
            "MLH": return 4;
            "HHL": return 5;
            "HML": return 8;
            default: return 15;
        endcase
    endfunction

    // ---------------- behavioural model: timeline relative to start edge
    int  cyc = 0, t0 = 0, k = 0, k2 = 0, hold_from = 0;
    int  sr = 0, sg = 0, sb = 0, c = 0;
    bit  mbusy = 0, pprev = 0, chk_on = 0, prev_valid = 0, mon = 0;
    int  e_cls = 0, e_stat = 0;
    logic [6:0] e_seg = '0;
    bit  e_valid = 0, e_ml = 0, e_mr = 0;
    int  counts [16];

    always @(posedge clk) begin
        cyc++;
        prev_valid = e_valid;
`ifdef COLOR_SORT_STATS_EN
        if (rst) begin
            foreach (counts[i]) counts[i] = 0;
            e_stat = 0;
        end else begin
            e_stat = counts[bus.stat_sel];
            if (prev_valid && counts[e_cls] < (1 << CNT_W) - 1) counts[e_cls]++;
        end
`else
        e_stat = 0;
`endif
        if (rst) begin
            mbusy = 0; pprev = 0; e_cls = 0; e_seg = '0;
        end else begin
            if (!mbusy) begin
                if (bus.p && !pprev) begin
                    mbusy = 1; t0 = cyc;
                    sr = bus.red; sg = bus.green; sb = bus.blue;
                end
            end else begin
                k = cyc - t0;
                if (k < NSAMP) begin
                    sr += bus.red; sg += bus.green; sb += bus.blue;
                end else if (k == NSAMP) begin
                    c = class_of(sr / NSAMP, sg / NSAMP, sb / NSAMP);
                    e_cls = c;
                    e_seg = glyph[c];
                    hold_from = NSAMP + ((c == 15) ? 0 : MC);
                end else if (k > hold_from && !bus.p) begin
                    mbusy = 0;
                end
            end
            pprev = bus.p;
        end
        k2      = cyc - t0;
        e_valid = mbusy && (k2 == NSAMP);
        mon     = mbusy && (e_cls != 15) && (k2 >= NSAMP) && (k2 < NSAMP + MC);
        e_ml    = mon && LMASK[e_cls];
        e_mr    = mon && !LMASK[e_cls];
        #1;
        if (chk_on) begin
            check("busy",      bus.busy,      mbusy);
            check("pn",        bus.pn,        mbusy);
            check("cls",       bus.cls,       e_cls);
            check("cls_valid", bus.cls_valid, e_valid);
            check("seg",       bus.seg,       e_seg);
            check("motor_l",   bus.motor_l,   e_ml);
            check("motor_r",   bus.motor_r,   e_mr);
            check("stat_cnt",  bus.stat_cnt,  e_stat);
        end
    end

    // ---------------- directed helpers
    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) begin done = 1; break; end
        end
        check({nm, "_idle_timeout"}, done, 1);
    endtask

    task automatic sort(input logic [7:0] r, g, b, input int ecls, input bit left);
        bit mot;
        mot = (ecls != 15);
        @(negedge clk);
        bus.red = r; bus.green = g; bus.blue = b; bus.p = 1'b1;
        repeat (NSAMP + 1) @(negedge clk);
        check("lit_cls",   bus.cls, ecls);
        check("lit_seg",   bus.seg, glyph[ecls]);
        check("lit_valid", bus.cls_valid, 1);
        check("lit_pn",    bus.pn, 1);
        check("lit_ml_on", bus.motor_l, mot && left);
        check("lit_mr_on", bus.motor_r, mot && !left);
        repeat (MC - 1) @(negedge clk);
        check("lit_ml_last", bus.motor_l, mot && left);
        check("lit_mr_last", bus.motor_r, mot && !left);
        @(negedge clk);
        check("lit_ml_off", bus.motor_l, 0);
        check("lit_mr_off", bus.motor_r, 0);
        bus.p = 1'b0;
        wait_idle("sort");
    endtask

    function automatic logic [7:0] pick();
        case ($urandom % 8)
            0: return 8'h00;
            1: return 8'h2F;
            2: return 8'h30;
            3: return 8'h96;
            4: return 8'h97;
            5: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.red = '0; bus.green = '0; bus.blue = '0; bus.p = 1'b0; bus.stat_sel = '0;
        @(negedge clk);
        @(negedge clk);
        chk_on = 1;
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_seg",  bus.seg, 0);
        check("rst_cls",  bus.cls, 0);
        check("rst_motors", {bus.motor_l, bus.motor_r}, 0);

        sort(8'h97, 8'h00, 8'h00, 1, 1);
        check("lit_seg_red", bus.seg, 7'b0110000);
        sort(8'h00, 8'h97, 8'h00, 2, 0);
        sort(8'h96, 8'h00, 8'h00, 15, 0);
        check("lit_seg_unk", bus.seg, 7'b0000001);
        sort(8'h33, 8'h00, 8'h97, 4, 1);
        sort(8'h97, 8'h97, 8'h00, 5, 1);
        sort(8'hFF, 8'hFF, 8'hFF, 6, 0);
        sort(8'h00, 8'h00, 8'h00, 0, 0);
        sort(8'hFF, 8'h7F, 8'h00, 8, 0);
        sort(8'h00, 8'h00, 8'h97, 3, 0);

        // Re-pulse p during DRIVE: ignored, motor still lasts MC clocks.
        @(negedge clk);
        bus.red = 8'h97; bus.green = 8'h00; bus.blue = 8'h00; bus.p = 1'b1;
        repeat (NSAMP + 2) @(negedge clk);
        bus.p = 1'b0;
        @(negedge clk); bus.p = 1'b1;
        @(negedge clk); bus.p = 1'b0;
        @(negedge clk);
        check("repulse_motor", bus.motor_l, 1);
        // p held high through HOLD, then released: no restart afterwards.
        bus.p = 1'b1;
        repeat (MC + 4) @(negedge clk);
        check("hold_busy", bus.busy, 1);
        bus.p = 1'b0;
        wait_idle("hold");
        repeat (3) @(negedge clk);
        check("no_restart", bus.busy, 0);

        // Reset in the middle of DRIVE.
        bus.p = 1'b1;
        repeat (NSAMP + 2) @(negedge clk);
        check("pre_rst_motor", bus.motor_l, 1);
        rst = 1'b1; bus.p = 1'b0;
        @(negedge clk);
        check("rst_mid_ml", bus.motor_l, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_seg", bus.seg, 0);
        rst = 1'b0;

`ifdef COLOR_SORT_STATS_EN
        sort(8'h97, 8'h00, 8'h00, 1, 1);
        sort(8'hA0, 8'h10, 8'h00, 1, 1);
        sort(8'hFF, 8'h2F, 8'h2F, 1, 1);
        bus.stat_sel = 4'h1;
        repeat (2) @(negedge clk);
        check("stat_red3", bus.stat_cnt, 3);
        bus.stat_sel = 4'h7;
        repeat (2) @(negedge clk);
        check("stat_unused", bus.stat_cnt, 0);
`endif

        // Randomised phase.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom % 8 == 0) begin
                bus.red = pick(); bus.green = pick(); bus.blue = pick();
            end
            if ($urandom % 6 == 0) bus.p = ~bus.p;
            bus.stat_sel = 4'($urandom);
            rst = ($urandom % 400 == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
